// File: rtl/uart_byte_tx_if.sv
// Byte-level transmit port of the UART: request/data in, line and status out.
interface uart_byte_tx_if;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overflow;

    modport master (
        output tx_data,
        output tx_enable,
        input  uart_txd,
        input  tx_busy,
        input  tx_done,
        input  tx_overflow
    );

    modport slave (
        input  tx_data,
        input  tx_enable,
        output uart_txd,
        output tx_busy,
        output tx_done,
        output tx_overflow
    );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with edge-triggered requests and a one-byte pending buffer.
module uart_byte_tx #(
    parameter logic [31:0] CLK_FREQ  = 32'd50_000_000,
    parameter logic [31:0] BAUD_RATE = 32'd115_200
) (
    input  logic           clk_50m,
    input  logic           reset,
    uart_byte_tx_if.slave  bus
);
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW =
        (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    frame, frame_n;
    logic [7:0]    buf_data;
    logic          buf_valid;
    logic          en_q, req_q;
    logic          txd_q, done_q, ovf_q;
    logic          txd_n, done_n, ovf_n;
    logic          tick, take;

    assign tick = (cnt == LAST);
    assign take = buf_valid &&
                  ((state == IDLE) || (state == STOP && tick));

    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + CW'(1);
        idx_n   = idx;
        frame_n = frame;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (buf_valid) begin
                    state_n = START;
                    frame_n = buf_data;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    // Chain straight into the next start bit.
                    if (buf_valid) begin
                        state_n = START;
                        frame_n = buf_data;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        txd_n = 1'b1;
        unique case (state_n)
            IDLE:  txd_n = 1'b1;
            START: txd_n = 1'b0;
            DATA:  txd_n = frame_n[idx_n];
            STOP:  txd_n = 1'b1;
        endcase
        done_n = (state_n == STOP) && (cnt_n == LAST);
        ovf_n  = req_q && buf_valid && !take;
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            frame <= 8'd0;
            txd_q <= 1'b1;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            frame <= frame_n;
            txd_q <= txd_n;
            done_q <= done_n;
            ovf_q <= ovf_n;
        end
    end

    // Capture one cycle after the detected edge; a take frees the slot.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            req_q     <= 1'b0;
            buf_data  <= 8'd0;
            buf_valid <= 1'b0;
        end else begin
            en_q  <= bus.tx_enable;
            req_q <= bus.tx_enable & ~en_q;
            if (req_q && (!buf_valid || take)) begin
                buf_data  <= bus.tx_data;
                buf_valid <= 1'b1;
            end else if (take) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign bus.uart_txd    = txd_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_overflow = ovf_q;
    assign bus.tx_busy     = (state != IDLE) | buf_valid | req_q;

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLK_FREQ, default 32'd50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 32'd115_200, serial bit rate in bit/s.
REQ-003 Port clk_50m  input  1  system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port tx_data  input  8  byte to send.
REQ-006 Port tx_enable  input  1  send request, rising-edge sensitive; level or pulse accepted.
REQ-007 Port uart_txd  output  1  serial line, idle high.
REQ-008 Port tx_busy  output  1  high while a frame is on the line or a byte is pending.
REQ-009 Port tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-010 Port tx_overflow  output  1  one-cycle pulse when a request is dropped.

Function
REQ-011 BAUD_DIV SHALL be CLK_FREQ/BAUD_RATE with integer truncation; 50 MHz / 115200 gives 434 clocks per bit.
REQ-012 The baud counter SHALL count 0..BAUD_DIV-1; each bit SHALL last exactly BAUD_DIV clocks.
REQ-013 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1, for 10*BAUD_DIV clocks per frame.
REQ-014 A request SHALL be tx_enable sampled 1 at edge k after being sampled 0 at edge k-1; a held-high level is a single request.
REQ-015 tx_data SHALL be captured at edge k+1, one cycle after the request is detected, so data driven together with enable is settled.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP and SHALL hold a 3-bit bit index.
REQ-017 IDLE->START: a captured byte is available; uart_txd SHALL go 0 at edge k+2 for an idle request.
REQ-018 START->DATA after BAUD_DIV clocks; DATA SHALL shift bit index 0..7, each for BAUD_DIV clocks; DATA->STOP after bit 7.
REQ-019 STOP drives 1 for BAUD_DIV clocks; tx_done SHALL pulse on the last STOP cycle.
REQ-020 STOP exit: go to START if a byte is pending, with no idle gap between frames; otherwise go to IDLE.
REQ-021 One-entry pending buffer: a byte captured while the FSM is not IDLE SHALL be stored if the buffer is empty.
REQ-022 Buffer full plus a new request: drop the new byte, keep the buffered byte, pulse tx_overflow at the capture edge.
REQ-023 The buffer SHALL load on the same edge that the FSM takes it at STOP exit; this edge is not an overflow.
REQ-024 tx_busy SHALL be 1 when the FSM is not IDLE or the buffer is full, and SHALL also cover the capture cycle k+1.
REQ-025 uart_txd, tx_done and tx_overflow SHALL be registered outputs, glitch-free.
REQ-026 A byte in flight SHALL never be altered by tx_data changes after capture.

Reset
REQ-027 While reset=1: state IDLE, uart_txd=1, tx_busy=0, tx_done=0, tx_overflow=0, counters 0, buffer empty, edge-detect history 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately: uart_txd=1 asynchronously and the pending byte is discarded.
REQ-029 After reset release, a tx_enable already high SHALL be treated as a request, because the history register is 0.

Verification (sim parameters CLK_FREQ=1000, BAUD_RATE=100, so BAUD_DIV=10)
REQ-030 Single byte: tx_data=8'hA5, tx_enable pulses 1 cycle -> uart_txd low at k+2 for 10 clocks, then 1,0,1,0,0,1,0,1 at 10 clocks each, stop high; tx_done pulse at k+101; tx_busy low after.
REQ-031 Back-to-back: 8'h01 then 8'h80 requested 30 clocks apart -> two contiguous frames, 200 clocks, no idle bits, two tx_done pulses 100 clocks apart, no overflow.
REQ-032 Overflow: three requests 8'h11, 8'h22, 8'h33 within one frame -> 8'h11 and 8'h22 sent, 8'h33 dropped, tx_overflow one pulse on the third capture.
REQ-033 Level enable: tx_enable held high for 500 clocks with tx_data=8'h3C -> exactly one frame sent.
REQ-034 Reset mid-frame: reset=1 during data bit 3 with a byte pending -> uart_txd=1 at once, all outputs at reset values, nothing sent after release until a new rising edge.
REQ-035 Data change after capture: tx_data switches 8'h55 to 8'hFF at k+2 -> 8'h55 transmitted.
